// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative unsigned MULU and DIVU.
// Latency: 1 cycle from accept for single-cycle ops and DIVU by zero, WIDTH+1 cycles for MULU/DIVU.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid & out_ready.
//
// Ports: clk, reset_n (async, active low); in_valid/in_ready with SrcA, SrcB, ALUControl;
//        out_valid/out_ready with ALUResult, ALUResultHi, Zero, Overflow, DivByZero.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic [WIDTH-1:0] ALUResultHi,
  output logic             Zero,
  output logic             Overflow,
  output logic             DivByZero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_lo;   // result low half; multiplier / dividend-quotient while BUSY
  logic [WIDTH-1:0] r_hi;   // result high half; partial product / remainder while BUSY
  logic [SHW-1:0]   r_cnt;
  logic             r_ovf;
  logic             r_dbz;

  logic [WIDTH-1:0] w_sum, w_diff, w_res;
  logic [SHW-1:0]   w_shamt;
  logic             w_ovf;
  logic             w_iter;
  logic [WIDTH:0]   w_mul_sum, w_div_rem, w_div_sub;
  logic             w_div_ge;

  assign w_sum   = SrcA + SrcB;
  assign w_diff  = SrcA - SrcB;
  assign w_shamt = SrcB[SHW-1:0];

  // Ops that need the iterative datapath; DIVU by zero is resolved immediately.
  assign w_iter = (ALUControl == OP_MULU) ||
                  ((ALUControl == OP_DIVU) && (SrcB != '0));

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (ALUControl)
      OP_AND:  w_res = SrcA & SrcB;
      OP_OR:   w_res = SrcA | SrcB;
      OP_NOR:  w_res = ~(SrcA | SrcB);
      OP_XOR:  w_res = SrcA ^ SrcB;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (w_diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_SLL:  w_res = SrcA << w_shamt;
      OP_SRL:  w_res = SrcA >> w_shamt;
      OP_SRA:  w_res = $unsigned($signed(SrcA) >>> w_shamt);
      default: w_res = '0;
    endcase
  end

  // Shift-add multiply: add multiplicand when the multiplier LSB is set, then shift the
  // {carry, hi, lo} pair right; after WIDTH steps {hi, lo} holds the full product.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Restoring divide: shift the next dividend bit into the remainder, subtract if it fits.
  // The remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits and
  // the subtraction MSB is a clean borrow flag.
  assign w_div_rem = {r_hi, r_lo[WIDTH-1]};
  assign w_div_sub = w_div_rem - {1'b0, r_b};
  assign w_div_ge  = ~w_div_sub[WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = w_iter ? S_BUSY : S_DONE;
      S_BUSY: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op  <= '0;
      r_b   <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op  <= ALUControl;
          r_b   <= SrcB;
          r_cnt <= SHW'(WIDTH - 1);
          r_ovf <= 1'b0;
          r_dbz <= 1'b0;
          if (w_iter) begin
            r_lo <= SrcA;
            r_hi <= '0;
          end else if (ALUControl == OP_DIVU) begin
            r_lo  <= '1;
            r_hi  <= SrcA;
            r_dbz <= 1'b1;
          end else begin
            r_lo  <= w_res;
            r_hi  <= '0;
            r_ovf <= w_ovf;
          end
        end
        S_BUSY: begin
          if (r_op == OP_MULU) begin
            {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= w_div_ge ? w_div_sub[WIDTH-1:0] : w_div_rem[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
          end
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign ALUResult   = r_lo;
  assign ALUResultHi = r_hi;
  assign Zero        = (r_lo == '0);
  assign Overflow    = r_ovf;
  assign DivByZero   = r_dbz;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32): directed vectors with hand-computed results,
// latency, hold-stability and in_ready-while-busy checks, plus reset abort of a MULU.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [3:0]  ALUControl = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] ALUResult, ALUResultHi;
  logic        Zero, Overflow, DivByZero;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .ALUResultHi(ALUResultHi),
    .Zero(Zero), .Overflow(Overflow), .DivByZero(DivByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] hi;
    logic        z, o, d;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever a result is consumed.
  logic        seen = 1'b0;
  int          lat_obs = 0;
  logic        stable = 1'b1;
  logic        rdy_bad = 1'b0;
  logic [31:0] snap_lo, snap_hi;
  logic [2:0]  snap_f;

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      seen    = 1'b0;
      stable  = 1'b1;
      rdy_bad = 1'b0;
    end else if (out_valid) begin
      if (!seen) begin
        seen    = 1'b1;
        stable  = 1'b1;
        snap_lo = ALUResult;
        snap_hi = ALUResultHi;
        snap_f  = {Zero, Overflow, DivByZero};
        lat_obs = (sb.size() > 0) ? (cyc - sb[0].acc + 1) : -1;
      end else if (ALUResult !== snap_lo || ALUResultHi !== snap_hi ||
                   {Zero, Overflow, DivByZero} !== snap_f) begin
        stable = 1'b0;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".res"}, ALUResult, e.res);
          chk({e.name, ".hi"}, ALUResultHi, e.hi);
          chk({e.name, ".zero"}, 32'(Zero), 32'(e.z));
          chk({e.name, ".ovf"}, 32'(Overflow), 32'(e.o));
          chk({e.name, ".dbz"}, 32'(DivByZero), 32'(e.d));
          chk({e.name, ".latency"}, 32'(lat_obs), 32'(e.lat));
          chk({e.name, ".held_stable"}, 32'(stable), 32'd1);
          chk({e.name, ".in_ready_low_while_busy"}, 32'(rdy_bad), 32'd0);
        end
        seen    = 1'b0;
        rdy_bad = 1'b0;
      end
    end else if (sb.size() > 0 && in_ready) begin
      rdy_bad = 1'b1;
    end
  end

  // Driver: presents an op, waits (bounded) for the accept edge, then queues the expectation.
  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a, b,
                       input logic [31:0] res, hi, input logic z, o, d, input int lat,
                       input bit push = 1'b1);
    exp_t e;
    logic rdy;
    bit   ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
    for (int n = 0; n < 200; n++) begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    in_valid = 1'b0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h0000_0003; ALUControl = 4'b0010;
    if (!ok) begin
      chk({nm, ".accept_timeout"}, 32'd0, 32'd1);
    end else if (push) begin
      e.name = nm; e.res = res; e.hi = hi; e.z = z; e.o = o; e.d = d;
      e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", ALUResult, 32'd0);
    chk("rst.result_hi", ALUResultHi, 32'd0);
    chk("rst.zero", 32'(Zero), 32'd1);
    chk("rst.flags", {30'd0, Overflow, DivByZero}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    //     name     op       SrcA          SrcB          res           hi         Z O D lat
    issue("add",    4'b0010, 32'd7,        32'd5,        32'hC,        32'd0,     0,0,0, 1);
    issue("sub_ov", 4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0,     0,1,0, 1);
    issue("sub_z",  4'b0110, 32'd5,        32'd5,        32'd0,        32'd0,     1,0,0, 1);
    issue("add_ov", 4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 32'd0,     0,1,0, 1);
    issue("slt",    4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,     0,0,0, 1);
    issue("sltu",   4'b0011, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,     1,0,0, 1);
    issue("sra",    4'b1010, 32'h80000000, 32'd4,        32'hF8000000, 32'd0,     0,0,0, 1);
    issue("and",    4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'd0,     0,0,0, 1);
    issue("or",     4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'd0,     0,0,0, 1);
    issue("nor",    4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 32'd0,     0,0,0, 1);
    issue("xor",    4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,     0,0,0, 1);
    issue("sll31",  4'b1000, 32'd1,        32'd31,       32'h80000000, 32'd0,     0,0,0, 1);
    issue("srl31",  4'b1001, 32'h80000000, 32'd31,       32'd1,        32'd0,     0,0,0, 1);
    issue("sll_lo", 4'b1000, 32'd3,        32'h21,       32'd6,        32'd0,     0,0,0, 1);
    issue("badop",  4'b1111, 32'd5,        32'd3,        32'd0,        32'd0,     1,0,0, 1);
    issue("mulu",   4'b1100, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1,     0,0,0, 33);
    issue("mulu2",  4'b1100, 32'h12345678, 32'h10,       32'h23456780, 32'd1,     0,0,0, 33);
    issue("divu",   4'b1101, 32'd100,      32'd7,        32'd14,       32'd2,     0,0,0, 33);
    issue("divu0",  4'b1101, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,     0,0,1, 1);
    wait_empty();

    // Consumer stalls for 5 cycles in DONE; the monitor checks the outputs stay put.
    out_ready = 1'b0;
    issue("hold",   4'b0010, 32'd1,        32'd2,        32'd3,        32'd0,     0,0,0, 1);
    for (int n = 0; n < 20 && !out_valid; n++) begin @(posedge clk); #1; end
    repeat (5) @(posedge clk);
    #1;
    chk("hold.still_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    wait_empty();

    // Abort a MULU with reset during BUSY.
    issue("mulu_abort", 4'b1100, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 0,0,0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("abort.busy_before_reset", 32'(in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.result", ALUResult, 32'd0);
    chk("abort.result_hi", ALUResultHi, 32'd0);
    chk("abort.zero", 32'(Zero), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("abort.no_result", 32'(bad), 32'd0);
    issue("post_rst_add", 4'b0010, 32'd1, 32'd1, 32'd2, 32'd0, 0,0,0, 1);
    wait_empty();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
